nabp_swap_control: RTL and testbench



---
 rtl/nabp_swap_control.sv | 165 ++++++++++++++++
 tb/tb_nabp_swap_control.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_swap_control.sv
// Swap/iteration controller for a pair of swappable processing units: arbitrates
// next_itr grants, hands out accumulator parameters, and pairs up swap requests.
module nabp_swap_control #(
  parameter int pItrs       = 8,
  parameter int pItrWidth   = 8,
  parameter int pShW        = 16,
  parameter int pMpInitW    = 16,
  parameter int pMpBaseW    = 16,
  parameter int pShInit     = 0,
  parameter int pShStep     = 1,
  parameter int pMpInitInit = 0,
  parameter int pMpInitStep = 1,
  parameter int pMpBaseInit = 0,
  parameter int pMpBaseStep = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [pItrWidth-1:0] itr,
  input  logic                 sw0_swap,
  input  logic                 sw0_next_itr,
  output logic                 sw0_swap_ack,
  output logic                 sw0_next_itr_ack,
  output logic                 sw0_itr_valid,
  output logic [pShW-1:0]      sw0_sh_accu_base,
  output logic [pMpInitW-1:0]  sw0_mp_accu_init,
  output logic [pMpBaseW-1:0]  sw0_mp_accu_base,
  input  logic                 sw1_swap,
  input  logic                 sw1_next_itr,
  output logic                 sw1_swap_ack,
  output logic                 sw1_next_itr_ack,
  output logic                 sw1_itr_valid,
  output logic [pShW-1:0]      sw1_sh_accu_base,
  output logic [pMpInitW-1:0]  sw1_mp_accu_init,
  output logic [pMpBaseW-1:0]  sw1_mp_accu_base,
  output logic [1:0]           dbg_state
);

  // Handshake: a request is a level held until its one-cycle ack; a request
  // still high while its ack is high is ignored, so it is eligible again a cycle later.

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic [pItrWidth-1:0] ITRS     = pItrWidth'(pItrs);
  localparam logic [pShW-1:0]      SH_INIT  = pShW'(pShInit);
  localparam logic [pShW-1:0]      SH_STEP  = pShW'(pShStep);
  localparam logic [pMpInitW-1:0]  MPI_INIT = pMpInitW'(pMpInitInit);
  localparam logic [pMpInitW-1:0]  MPI_STEP = pMpInitW'(pMpInitStep);
  localparam logic [pMpBaseW-1:0]  MPB_INIT = pMpBaseW'(pMpBaseInit);
  localparam logic [pMpBaseW-1:0]  MPB_STEP = pMpBaseW'(pMpBaseStep);

  state_e                 state_q, state_d;
  logic [pItrWidth-1:0]   itr_q;
  logic [pShW-1:0]        sh_acc_q;
  logic [pMpInitW-1:0]    mpi_acc_q;
  logic [pMpBaseW-1:0]    mpb_acc_q;
  logic [1:0]             exh_q;
  logic [1:0]             nack_q;
  logic                   swack_q;
  logic [1:0]             valid_q;
  logic [pShW-1:0]        sh_q  [2];
  logic [pMpInitW-1:0]    mpi_q [2];
  logic [pMpBaseW-1:0]    mpb_q [2];

  logic       run;
  logic       start_run;
  logic       have_itr;
  logic       swap_go;
  logic [1:0] elig;
  logic [1:0] gnt;

  always_comb begin
    run       = (state_q == ST_RUN);
    start_run = (state_q == ST_IDLE) && start;
    have_itr  = (itr_q < ITRS);
    elig      = {sw1_next_itr, sw0_next_itr} & ~nack_q & {2{run}};
    // Unit 0 has fixed priority; a losing unit 1 is served the following cycle.
    gnt       = {elig[1] & ~elig[0], elig[0]};
    swap_go   = run && sw0_swap && sw1_swap && !swack_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (&exh_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      itr_q     <= '0;
      sh_acc_q  <= '0;
      mpi_acc_q <= '0;
      mpb_acc_q <= '0;
      exh_q     <= '0;
      nack_q    <= '0;
      swack_q   <= 1'b0;
      valid_q   <= '0;
      for (int n = 0; n < 2; n++) begin
        sh_q[n]  <= '0;
        mpi_q[n] <= '0;
        mpb_q[n] <= '0;
      end
    end else begin
      nack_q  <= gnt;
      swack_q <= swap_go;
      for (int n = 0; n < 2; n++) begin
        if (gnt[n]) begin
          if (have_itr) begin
            sh_q[n]    <= sh_acc_q;
            mpi_q[n]   <= mpi_acc_q;
            mpb_q[n]   <= mpb_acc_q;
            valid_q[n] <= 1'b1;
          end else begin
            valid_q[n] <= 1'b0;
            exh_q[n]   <= 1'b1;
          end
        end
      end
      if (start_run) begin
        itr_q     <= '0;
        sh_acc_q  <= SH_INIT;
        mpi_acc_q <= MPI_INIT;
        mpb_acc_q <= MPB_INIT;
        exh_q     <= '0;
      end else if ((|gnt) && have_itr) begin
        itr_q     <= itr_q + 1'b1;
        sh_acc_q  <= sh_acc_q + SH_STEP;
        mpi_acc_q <= mpi_acc_q + MPI_STEP;
        mpb_acc_q <= mpb_acc_q + MPB_STEP;
      end
    end
  end

  assign itr              = itr_q;
  assign sw0_swap_ack     = swack_q;
  assign sw1_swap_ack     = swack_q;
  assign sw0_next_itr_ack = nack_q[0];
  assign sw1_next_itr_ack = nack_q[1];
  assign sw0_itr_valid    = valid_q[0];
  assign sw1_itr_valid    = valid_q[1];
  assign sw0_sh_accu_base = sh_q[0];
  assign sw1_sh_accu_base = sh_q[1];
  assign sw0_mp_accu_init = mpi_q[0];
  assign sw1_mp_accu_init = mpi_q[1];
  assign sw0_mp_accu_base = mpb_q[0];
  assign sw1_mp_accu_base = mpb_q[1];

endmodule

// File: tb/tb_nabp_swap_control.sv
// Directed bench for nabp_swap_control: instance 0 exercises arbitration and completion,
// instance 1 (4-bit shifter accumulator) exercises wrap-around and mid-run reset.
module tb_nabp_swap_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        start [2];
  logic        swap  [2][2];
  logic        nreq  [2][2];
  logic        busy  [2];
  logic        done  [2];
  logic [7:0]  itr   [2];
  logic        swack [2][2];
  logic        nack  [2][2];
  logic        vld   [2][2];
  logic [1:0]  dbg   [2];
  logic [15:0] a_sh  [2];
  logic [15:0] a_mpi [2];
  logic [15:0] a_mpb [2];
  logic [3:0]  w_sh  [2];
  logic [15:0] w_mpi [2];
  logic [15:0] w_mpb [2];

  nabp_swap_control #(
    .pItrs(4), .pShInit(10), .pShStep(3), .pMpInitInit(5), .pMpInitStep(2),
    .pMpBaseInit(100), .pMpBaseStep(7)
  ) u_dut (
    .clk(clk), .reset_n(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .itr(itr[0]),
    .sw0_swap(swap[0][0]), .sw0_next_itr(nreq[0][0]), .sw0_swap_ack(swack[0][0]),
    .sw0_next_itr_ack(nack[0][0]), .sw0_itr_valid(vld[0][0]), .sw0_sh_accu_base(a_sh[0]),
    .sw0_mp_accu_init(a_mpi[0]), .sw0_mp_accu_base(a_mpb[0]),
    .sw1_swap(swap[0][1]), .sw1_next_itr(nreq[0][1]), .sw1_swap_ack(swack[0][1]),
    .sw1_next_itr_ack(nack[0][1]), .sw1_itr_valid(vld[0][1]), .sw1_sh_accu_base(a_sh[1]),
    .sw1_mp_accu_init(a_mpi[1]), .sw1_mp_accu_base(a_mpb[1]),
    .dbg_state(dbg[0])
  );

  nabp_swap_control #(
    .pItrs(4), .pShW(4), .pShInit(14), .pShStep(1)
  ) u_wrap (
    .clk(clk), .reset_n(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .itr(itr[1]),
    .sw0_swap(swap[1][0]), .sw0_next_itr(nreq[1][0]), .sw0_swap_ack(swack[1][0]),
    .sw0_next_itr_ack(nack[1][0]), .sw0_itr_valid(vld[1][0]), .sw0_sh_accu_base(w_sh[0]),
    .sw0_mp_accu_init(w_mpi[0]), .sw0_mp_accu_base(w_mpb[0]),
    .sw1_swap(swap[1][1]), .sw1_next_itr(nreq[1][1]), .sw1_swap_ack(swack[1][1]),
    .sw1_next_itr_ack(nack[1][1]), .sw1_itr_valid(vld[1][1]), .sw1_sh_accu_base(w_sh[1]),
    .sw1_mp_accu_init(w_mpi[1]), .sw1_mp_accu_base(w_mpb[1]),
    .dbg_state(dbg[1])
  );

  int tests = 0;
  int fails = 0;
  logic [56:0] exp_q[$];

  // Reference model: {valid, itr, sh, mp_init, mp_base} per grant.
  int     m_itr [2];
  longint acc_sh [2], acc_mpi [2], acc_mpb [2];
  longint l_sh [2][2], l_mpi [2][2], l_mpb [2][2];

  function automatic longint sh_init(int i);  return (i == 0) ? 10 : 14; endfunction
  function automatic longint sh_step(int i);  return (i == 0) ? 3 : 1; endfunction
  function automatic longint sh_mask(int i);  return (i == 0) ? 'hFFFF : 'hF; endfunction
  function automatic longint mpi_init(int i); return (i == 0) ? 5 : 0; endfunction
  function automatic longint mpi_step(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic longint mpb_init(int i); return (i == 0) ? 100 : 0; endfunction
  function automatic longint mpb_step(int i); return (i == 0) ? 7 : 1; endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start(input int i);
    m_itr[i]   = 0;
    acc_sh[i]  = sh_init(i);
    acc_mpi[i] = mpi_init(i);
    acc_mpb[i] = mpb_init(i);
  endtask

  task automatic model_reset(input int i);
    m_itr[i] = 0; acc_sh[i] = 0; acc_mpi[i] = 0; acc_mpb[i] = 0;
    for (int u = 0; u < 2; u++) begin
      l_sh[i][u] = 0; l_mpi[i][u] = 0; l_mpb[i][u] = 0;
    end
  endtask

  task automatic model_grant(input int i, input int u);
    logic v;
    v = (m_itr[i] < 4);
    if (v) begin
      l_sh[i][u]  = acc_sh[i];
      l_mpi[i][u] = acc_mpi[i];
      l_mpb[i][u] = acc_mpb[i];
      acc_sh[i]   = (acc_sh[i] + sh_step(i)) & sh_mask(i);
      acc_mpi[i]  = (acc_mpi[i] + mpi_step(i)) & 'hFFFF;
      acc_mpb[i]  = (acc_mpb[i] + mpb_step(i)) & 'hFFFF;
      m_itr[i]++;
    end
    exp_q.push_back({v, 8'(m_itr[i]), 16'(l_sh[i][u]), 16'(l_mpi[i][u]), 16'(l_mpb[i][u])});
  endtask

  function automatic logic [56:0] obs_grant(input int i, input int u);
    logic [15:0] sh;
    sh = (i == 0) ? a_sh[u] : {12'd0, w_sh[u]};
    return {vld[i][u], itr[i], sh, (i == 0) ? a_mpi[u] : w_mpi[u],
            (i == 0) ? a_mpb[u] : w_mpb[u]};
  endfunction

  function automatic logic [127:0] all_out(input int i);
    if (i == 0)
      return 128'({busy[0], done[0], itr[0], swack[0][0], swack[0][1], nack[0][0], nack[0][1],
                   vld[0][0], vld[0][1], a_sh[0], a_sh[1], a_mpi[0], a_mpi[1],
                   a_mpb[0], a_mpb[1], dbg[0]});
    return 128'({busy[1], done[1], itr[1], swack[1][0], swack[1][1], nack[1][0], nack[1][1],
                 vld[1][0], vld[1][1], w_sh[0], w_sh[1], w_mpi[0], w_mpi[1],
                 w_mpb[0], w_mpb[1], dbg[1]});
  endfunction

  task automatic pop_cmp(input string tag, input int i, input int u);
    logic [56:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 128'(1), 128'(0));
    end else begin
      e = exp_q.pop_front();
      check(tag, 128'(obs_grant(i, u)), 128'(e));
    end
  endtask

  // Raise a request, wait (bounded) for its ack, score it, drop it, step one more cycle.
  task automatic do_req(input int i, input int u);
    int n;
    string tag;
    tag = $sformatf("grant_i%0d_u%0d_k%0d", i, u, m_itr[i]);
    nreq[i][u] = 1'b1;
    model_grant(i, u);
    n = 0;
    do begin
      tick();
      n++;
    end while (!nack[i][u] && n < 8);
    check({tag, "_ack"}, 128'(nack[i][u]), 128'(1));
    pop_cmp(tag, i, u);
    nreq[i][u] = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 128'(nack[i][u]), 128'(0));
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      model_reset(i);
    end
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = 1'($urandom_range(0, 1));
        for (int u = 0; u < 2; u++) begin
          swap[i][u] = 1'($urandom_range(0, 1));
          nreq[i][u] = 1'($urandom_range(0, 1));
        end
      end
      tick();
    end
    check("reset_outputs_i0", all_out(0), 128'(0));
    check("reset_outputs_i1", all_out(1), 128'(0));
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      rst_n[i] = 1'b1;
      for (int u = 0; u < 2; u++) begin
        swap[i][u] = 1'b0;
        nreq[i][u] = 1'b0;
      end
    end
    tick();
    check("idle_busy", 128'(busy[0]), 128'(0));

    // Run 1: unit 0 alone, 10/13/16/19 then exhausted.
    pulse_start(0);
    model_start(0);
    check("start_busy", 128'(busy[0]), 128'(1));
    check("start_itr", 128'(itr[0]), 128'(0));
    do_req(0, 0);
    do_req(0, 0);

    pulse_start(0);
    check("midrun_start_itr", 128'(itr[0]), 128'(2));
    check("midrun_start_state", 128'(dbg[0]), 128'(1));

    swap[0][0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("lone_swap_c%0d", c), 128'({swack[0][0], swack[0][1]}), 128'(0));
    end
    swap[0][1] = 1'b1;
    tick();
    check("swap_pair_ack", 128'({swack[0][0], swack[0][1]}), 128'(3));
    swap[0][0] = 1'b0;
    swap[0][1] = 1'b0;
    tick();
    check("swap_ack_pulse", 128'({swack[0][0], swack[0][1]}), 128'(0));

    do_req(0, 0);
    do_req(0, 0);
    do_req(0, 0);
    check("one_exhausted_busy", 128'({busy[0], done[0]}), 128'(2));
    do_req(0, 1);
    check("done_pulse", 128'({busy[0], done[0]}), 128'(3));
    tick();
    check("done_after", 128'({busy[0], done[0], dbg[0]}), 128'(0));

    // Run 2: simultaneous requests, unit 0 first.
    pulse_start(0);
    model_start(0);
    nreq[0][0] = 1'b1;
    nreq[0][1] = 1'b1;
    model_grant(0, 0);
    model_grant(0, 1);
    tick();
    check("contend_first_acks", 128'({nack[0][0], nack[0][1]}), 128'(2));
    pop_cmp("contend_u0_k0", 0, 0);
    nreq[0][0] = 1'b0;
    tick();
    check("contend_second_acks", 128'({nack[0][0], nack[0][1]}), 128'(1));
    pop_cmp("contend_u1_k1", 0, 1);
    nreq[0][1] = 1'b0;
    tick();

    // Wrap on the 4-bit instance: 14, 15, 0, then reset between grants.
    pulse_start(1);
    model_start(1);
    do_req(1, 0);
    do_req(1, 0);
    do_req(1, 0);
    rst_n[1] = 1'b0;
    tick();
    model_reset(1);
    check("midrun_reset_i1", all_out(1), 128'(0));
    rst_n[1] = 1'b1;
    tick();
    pulse_start(1);
    model_start(1);
    do_req(1, 0);

    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
